// File: rtl/dmem_pkg.sv
// Shared types and helpers for the parametrised data memory: FSM state encoding,
// index-width helper and the power-on fill pattern.
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DEPTH = 32;
    localparam int IDX_W         = $clog2(DEFAULT_DEPTH);

    function automatic int idx_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Lower half of the array counts up from 0, upper half counts down from 0 in
    // two's complement; computed one bit wider than the word, then masked.
    function automatic logic [63:0] init_pattern(input int i, input int depth, input int data_w);
        logic signed [64:0] v;
        if (i < depth / 2)
            v = 65'(i);
        else
            v = -65'(i - depth / 2);
        if (data_w < 64)
            v = v & ((65'sd1 <<< data_w) - 65'sd1);
        return v[63:0];
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port storage array with a registered read port; same-address
// read/write ordering is selected by WRITE_FIRST.
module dmem_array #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int IDX_W       = 5,
    parameter int WRITE_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents carry no reset; the caller gates we during reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (rzero) begin
            rdata <= '0;
        end else if (re) begin
            if (WRITE_FIRST != 0 && we)
                rdata <= wdata;
            else
                rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_param.sv
// Parametrised data memory: power-on fill walk, registered read, range check
// and status strobes around the dmem_array storage.
module dmem_param
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 8,
    parameter int WRITE_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] out,
    output logic              outValid,
    output logic              ready,
    output logic              addrFault
);

    localparam int IDXW = idx_width(DEPTH);

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic              legal;
    logic              arr_we;
    logic              arr_re;
    logic              arr_zero;
    logic [IDXW-1:0]   arr_addr;
    logic [DATA_W-1:0] arr_wdata;

    assign legal = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

    // In INIT the walker owns the write port and user requests are ignored.
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_zero  = 1'b0;
        arr_addr  = idx;
        arr_wdata = DATA_W'(init_pattern(int'(idx), DEPTH, DATA_W));
        if (!reset) begin
            if (state == INIT) begin
                arr_we = 1'b1;
            end else begin
                arr_addr  = addr[IDXW-1:0];
                arr_wdata = writeData;
                arr_we    = MemWrite && legal;
                arr_re    = MemRead && legal;
                arr_zero  = MemRead && !legal;
            end
        end
    end

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .IDX_W       (IDXW),
        .WRITE_FIRST (WRITE_FIRST)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .re    (arr_re),
        .rzero (arr_zero),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            idx       <= '0;
            ready     <= 1'b0;
            outValid  <= 1'b0;
            addrFault <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    outValid  <= 1'b0;
                    addrFault <= 1'b0;
                    idx       <= idx + 1'b1;
                    if (idx == IDXW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    outValid  <= MemRead;
                    addrFault <= (MemRead || MemWrite) && !legal;
                end
                default: begin
                    state <= INIT;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_param.sv
// Scoreboard bench for dmem_param: two 8x32 instances (write-first and
// read-first) driven in lockstep, plus a 16x8 instance.
module tb_dmem_param;

    typedef struct {
        logic        vld;
        logic        fault;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr, wdata;
    logic        rd, wr;
    logic [7:0]  out0, out1;
    logic        ov0, ov1, rdy0, rdy1, af0, af1;
    logic [7:0]  addr2;
    logic [15:0] wdata2, out2;
    logic        rd2, wr2, ov2, rdy2, af2;

    exp_t q0[$], q1[$], q2[$];
    logic [7:0] mdl [32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_param #(.DATA_W(8), .DEPTH(32), .ADDR_W(8), .WRITE_FIRST(1)) u0 (
        .clk(clk), .reset(reset), .addr(addr), .writeData(wdata), .MemRead(rd),
        .MemWrite(wr), .out(out0), .outValid(ov0), .ready(rdy0), .addrFault(af0));

    dmem_param #(.DATA_W(8), .DEPTH(32), .ADDR_W(8), .WRITE_FIRST(0)) u1 (
        .clk(clk), .reset(reset), .addr(addr), .writeData(wdata), .MemRead(rd),
        .MemWrite(wr), .out(out1), .outValid(ov1), .ready(rdy1), .addrFault(af1));

    dmem_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(8), .WRITE_FIRST(1)) u2 (
        .clk(clk), .reset(reset), .addr(addr2), .writeData(wdata2), .MemRead(rd2),
        .MemWrite(wr2), .out(out2), .outValid(ov2), .ready(rdy2), .addrFault(af2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic v, input logic f,
                       input logic [15:0] d);
        check({tag, "_valid"}, 32'(v), 32'(e.vld));
        check({tag, "_fault"}, 32'(f), 32'(e.fault));
        if (e.vld)
            check({tag, "_data"}, 32'(d), 32'(e.data));
    endtask

    task automatic unexpected(input string tag, input logic v, input logic f, input logic [15:0] d);
        checks++;
        failures++;
        $display("FAIL %s_unexpected actual=valid:%b fault:%b data:%h required=no output",
                 tag, v, f, d);
    endtask

    // Monitor: pops one expectation whenever a DUT strobes valid or fault.
    always @(negedge clk) begin
        exp_t e;
        if (ov0 || af0) begin
            if (q0.size() == 0) unexpected("u0", ov0, af0, {8'h00, out0});
            else begin e = q0.pop_front(); cmp("u0", e, ov0, af0, {8'h00, out0}); end
        end
        if (ov1 || af1) begin
            if (q1.size() == 0) unexpected("u1", ov1, af1, {8'h00, out1});
            else begin e = q1.pop_front(); cmp("u1", e, ov1, af1, {8'h00, out1}); end
        end
        if (ov2 || af2) begin
            if (q2.size() == 0) unexpected("u2", ov2, af2, out2);
            else begin e = q2.pop_front(); cmp("u2", e, ov2, af2, out2); end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request to u0/u1; e0/e1 are the hand-derived read results.
    task automatic op(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] e0, input logic [7:0] e1);
        logic flt;
        flt = (r || w) && (a >= 8'd32);
        rd = r; wr = w; addr = a; wdata = d;
        if (r || flt) begin
            q0.push_back('{vld: r, fault: flt, data: {8'h00, e0}});
            q1.push_back('{vld: r, fault: flt, data: {8'h00, e1}});
        end
        step();
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic init_walk(input string tag);
        for (int i = 1; i <= 31; i++) begin
            if (i == 10) begin
                rd = 1'b1; wr = 1'b1; addr = 8'd2; wdata = 8'hEE;
            end
            step();
            rd = 1'b0; wr = 1'b0;
            check({tag, "_ready_low"}, 32'(rdy0), 32'd0);
            check({tag, "_init_out"}, 32'(out0), 32'd0);
        end
        step();
        check({tag, "_ready_high_u0"}, 32'(rdy0), 32'd1);
        check({tag, "_ready_high_u1"}, 32'(rdy1), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'(i);
        for (int i = 16; i < 32; i++) mdl[i] = 8'(256 - (i - 16));

        step();
        reset = 1'b0;
        check("rst_out", 32'(out0), 32'd0);
        check("rst_valid", 32'(ov0), 32'd0);
        check("rst_ready", 32'(rdy0), 32'd0);
        check("rst_fault", 32'(af0), 32'd0);
        init_walk("walk1");

        op(1'b1, 1'b0, 8'd0,  8'h00, 8'h00, 8'h00);
        op(1'b1, 1'b0, 8'd15, 8'h00, 8'h0F, 8'h0F);
        op(1'b1, 1'b0, 8'd16, 8'h00, 8'h00, 8'h00);
        op(1'b1, 1'b0, 8'd17, 8'h00, 8'hFF, 8'hFF);
        op(1'b1, 1'b0, 8'd31, 8'h00, 8'hF1, 8'hF1);

        op(1'b0, 1'b1, 8'd5, 8'hA5, 8'h00, 8'h00);
        op(1'b1, 1'b0, 8'd5, 8'h00, 8'hA5, 8'hA5);
        step();
        check("hold_valid", 32'(ov0), 32'd0);
        check("hold_out", 32'(out0), 32'hA5);

        op(1'b1, 1'b1, 8'd7, 8'h3C, 8'h3C, 8'h07);
        op(1'b1, 1'b0, 8'd7, 8'h00, 8'h3C, 8'h3C);

        op(1'b1, 1'b0, 8'd40,  8'h00, 8'h00, 8'h00);
        op(1'b1, 1'b0, 8'd32,  8'h00, 8'h00, 8'h00);
        op(1'b0, 1'b1, 8'd200, 8'h5A, 8'h00, 8'h00);
        op(1'b1, 1'b1, 8'd33,  8'h77, 8'h00, 8'h00);

        mdl[5] = 8'hA5;
        mdl[7] = 8'h3C;
        for (int i = 0; i < 32; i++)
            op(1'b1, 1'b0, 8'(i), 8'h00, mdl[i], mdl[i]);

        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_out", 32'(out0), 32'd0);
        check("rst2_ready", 32'(rdy0), 32'd0);
        init_walk("walk2");
        op(1'b1, 1'b0, 8'd5, 8'h00, 8'h05, 8'h05);
        op(1'b1, 1'b0, 8'd7, 8'h00, 8'h07, 8'h07);
        op(1'b1, 1'b0, 8'd2, 8'h00, 8'h02, 8'h02);

        check("u2_ready", 32'(rdy2), 32'd1);
        rd2 = 1'b1; addr2 = 8'd6;
        q2.push_back('{vld: 1'b1, fault: 1'b0, data: 16'hFFFE});
        step();
        addr2 = 8'd3;
        q2.push_back('{vld: 1'b1, fault: 1'b0, data: 16'h0003});
        step();
        addr2 = 8'd8;
        q2.push_back('{vld: 1'b1, fault: 1'b1, data: 16'h0000});
        step();
        rd2 = 1'b0;

        step();
        step();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
